// File: rtl/scalar_regs.sv
// scalar_regs: small NPU scalar register file (scale, bias, shift, ...).
// One synchronous write port, one combinational read port, and every
// register exported in parallel on registers_out.
// Optional build macro SCALAR_REGS_BYPASS_EN: write-through forwarding of
// write_data onto read_data when the write and read hit the same register.
module scalar_regs #(
    parameter int WIDTH       = 16,
    parameter int NUM_SCALARS = 4,
    parameter int WA          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(NUM_SCALARS)-1:0] read_addr,
    output logic [WIDTH-1:0]               read_data,
    input  logic                           we,
    input  logic [WA-1:0]                  write_addr,
    input  logic [WIDTH-1:0]               write_data,
    output logic [WIDTH-1:0]               registers_out [NUM_SCALARS]
);

    localparam int RA = $clog2(NUM_SCALARS);

    logic [WIDTH-1:0]       scalar_reg [NUM_SCALARS];
    logic [NUM_SCALARS-1:0] write_hit;
    logic [NUM_SCALARS-1:0] read_hit;
    logic [WIDTH-1:0]       read_data_next;

    // Address decode per register. The write compare uses the full write
    // address width, so out-of-range addresses match no register at all
    // instead of aliasing onto a low register.
    generate
        for (genvar gi = 0; gi < NUM_SCALARS; gi++) begin : gen_slot
            assign write_hit[gi]     = we && (write_addr == WA'(gi));
            assign read_hit[gi]      = (read_addr == RA'(gi));
            assign registers_out[gi] = scalar_reg[gi];
        end
    endgenerate

    // Storage: cleared asynchronously, loaded from write_data on a decoded hit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCALARS; i++) begin
                scalar_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCALARS; i++) begin
                if (write_hit[i]) begin
                    scalar_reg[i] <= write_data;
                end
            end
        end
    end

    // Combinational read mux; an unmatched read address yields zero.
    always_comb begin
        read_data_next = '0;
        for (int i = 0; i < NUM_SCALARS; i++) begin
            if (read_hit[i]) begin
                read_data_next = scalar_reg[i];
            end
        end
`ifdef SCALAR_REGS_BYPASS_EN
        // Same-cycle forwarding of an in-range write aimed at the read slot.
        if (|(write_hit & read_hit)) begin
            read_data_next = write_data;
        end
`else
`endif
        // Reset dominates, including over any forwarded value.
        if (rst) begin
            read_data_next = '0;
        end
    end

    assign read_data = read_data_next;

endmodule

// File: tb/tb_scalar_regs.sv
// Directed bench for scalar_regs: expected values come from a bench-side
// model and pass through a scoreboard queue before comparison.
module tb_scalar_regs;

    localparam int WIDTH = 16;
    localparam int NUM   = 4;
    localparam int WA    = 4;

    logic             clk;
    logic             rst;
    logic [1:0]       read_addr;
    logic [WIDTH-1:0] read_data;
    logic             we;
    logic [WA-1:0]    write_addr;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] regs_out [NUM];

    scalar_regs #(.WIDTH(WIDTH), .NUM_SCALARS(NUM), .WA(WA)) dut (
        .clk           (clk),
        .rst           (rst),
        .read_addr     (read_addr),
        .read_data     (read_data),
        .we            (we),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .registers_out (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] value;
    } exp_t;

    exp_t             sb [$];
    logic [WIDTH-1:0] model [NUM];
    int               checks   = 0;
    int               failures = 0;

    task automatic push_exp(input string tag, input logic [WIDTH-1:0] v);
        exp_t e;
        e.tag   = tag;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [WIDTH-1:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.value) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
            $display("check %s observed=%h expected=%h", e.tag, obs, e.value);
        end
    endtask

    // Compare every parallel output against the model.
    task automatic check_all(input string tag);
        for (int i = 0; i < NUM; i++) begin
            push_exp($sformatf("%s_regs_out%0d", tag, i), model[i]);
            check(regs_out[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [WA-1:0] a, input logic [WIDTH-1:0] d);
        we         = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        if (a < NUM) model[a[1:0]] = d;
        $display("write addr=%0d data=%h", a, d);
    endtask

    initial begin
        logic [WIDTH-1:0] fill [NUM];
        fill[0] = 16'h1234;
        fill[1] = 16'h5678;
        fill[2] = 16'h9ABC;
        fill[3] = 16'hDEF0;
        for (int i = 0; i < NUM; i++) model[i] = '0;

        rst        = 1'b1;
        we         = 1'b0;
        read_addr  = 2'd0;
        write_addr = '0;
        write_data = '0;
        #2;
        push_exp("reset_read", 16'h0000);
        check(read_data);
        check_all("reset");

        // Write attempted while reset is held must be dropped.
        we         = 1'b1;
        write_addr = 4'd0;
        write_data = 16'hAAAA;
        tick();
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("write_in_reset");

        // Sequential fill on consecutive edges.
        for (int i = 0; i < NUM; i++) do_write(WA'(i), fill[i]);
        we = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            read_addr = 2'(i);
            #1;
            push_exp($sformatf("fill_read%0d", i), fill[i]);
            check(read_data);
            push_exp($sformatf("fill_out%0d", i), read_data);
            check(regs_out[i]);
        end

        // Write-enable gating.
        we         = 1'b0;
        write_addr = 4'd1;
        write_data = 16'hFFFF;
        repeat (3) tick();
        check_all("we_gating");

        // Out-of-range writes, including ones that would alias if truncated.
        do_write(4'hA, 16'hBEEF);
        do_write(4'h4, 16'hBEEF);
        do_write(4'hF, 16'hBEEF);
        we = 1'b0;
        check_all("out_of_range");

        // Same-address read and write.
        @(negedge clk);
        read_addr  = 2'd2;
        we         = 1'b1;
        write_addr = 4'd2;
        write_data = 16'h0F0F;
        #1;
`ifdef SCALAR_REGS_BYPASS_EN
        push_exp("rw_before_edge", 16'h0F0F);
`else
        push_exp("rw_before_edge", 16'h9ABC);
`endif
        check(read_data);
        tick();
        model[2] = 16'h0F0F;
        we = 1'b0;
        push_exp("rw_after_edge", 16'h0F0F);
        check(read_data);
        check_all("rw_same");

        // Combinational read with no clock edge in between.
        @(negedge clk);
        read_addr = 2'd3;
        #1;
        push_exp("comb_read3", 16'hDEF0);
        check(read_data);
        read_addr = 2'd0;
        #1;
        push_exp("comb_read0", 16'h1234);
        check(read_data);

        // Mid-run asynchronous reset, checked before any clock edge.
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NUM; i++) model[i] = '0;
        push_exp("async_reset_read", 16'h0000);
        check(read_data);
        check_all("async_reset");
        we         = 1'b1;
        write_addr = 4'd1;
        write_data = 16'h7777;
        tick();
        we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("write_blocked_in_reset");

        // Writes resume after reset release.
        do_write(4'd3, 16'h4242);
        we        = 1'b0;
        read_addr = 2'd3;
        #1;
        push_exp("post_reset_read3", 16'h4242);
        check(read_data);
        check_all("post_reset");

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scalar_regs.md
Name: scalar_regs

Overview:
- Small scalar register file: NUM_SCALARS registers, each WIDTH bits wide, for the NPU datapath.
- One synchronous write port and one combinational read port.
- Every register is also exported in parallel on registers_out, so downstream compute units can use all scalars at once.
- Holds per-layer scalars such as scale, bias and shift values that the control path loads.

Parameters:
- WIDTH, 16, bit width of each scalar register.
- NUM_SCALARS, 4, number of registers (must be ≥2). Read address width RA = $clog2(NUM_SCALARS).
- WA, 4, write address width (must satisfy 2**WA ≥ NUM_SCALARS).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_addr  input  RA (2)  read port register index.
- read_data  output  WIDTH  contents of the register selected by read_addr.
- we  input  1  write enable, sampled on rising clk.
- write_addr  input  WA (4)  write register index.
- write_data  input  WIDTH  data to write.
- registers_out  output  [WIDTH-1:0] x NUM_SCALARS (unpacked array)  registers_out[i] is the contents of register i.

Behaviour:
- Storage is NUM_SCALARS x WIDTH flops.
- Reset:
  - rst high clears every register to 0 immediately, without waiting for a clock.
  - While rst is high, read_data and every registers_out[i] read 0, and writes are blocked.
  - Writes resume on the first rising clk after rst deasserts.
- Write:
  - On a rising clk with we=1 and write_addr < NUM_SCALARS, reg[write_addr] <= write_data.
  - The new value is visible on outputs right after that edge (1-cycle write latency).
  - With we=0 all registers hold.
- Out-of-range write: write_addr ≥ NUM_SCALARS (e.g. 4..15 at the defaults) is silently ignored; no register changes and there is no wrap-around. Upper write_addr bits are never truncated.
- Read:
  - read_data = reg[read_addr], purely combinational with zero latency; it follows read_addr changes within the same cycle.
  - If read_addr ≥ NUM_SCALARS (possible only when NUM_SCALARS is not a power of two), read_data = 0.
- registers_out: purely combinational and continuous; registers_out[i] = reg[i] for all i.
- Simultaneous read and write to the same address (default build): read_data shows the old value until the clock edge, then the new value. There is no bypass.
- Any number of back-to-back writes on consecutive cycles is supported; there is no handshake.
- Outputs must not contain X after reset, regardless of the inputs.

Optional Feature:
- Macro: SCALAR_REGS_BYPASS_EN.
- Defined:
  - When we=1, write_addr is in range, and write_addr == read_addr, read_data = write_data combinationally in the same cycle (write-through forwarding).
  - registers_out is not bypassed and still shows stored values.
  - rst still forces read_data to 0.
- Undefined: no forwarding; read_data always reflects stored contents.

Test Plan:
- Reset: assert rst mid-simulation after writes, without a clock edge -> read_data and all registers_out = 0x0000 immediately; a write attempted while rst is high is not stored.
- Sequential fill: we=1, write 0x1234, 0x5678, 0x9ABC, 0xDEF0 to addresses 0..3 on consecutive edges, then we=0 -> read_addr 0..3 gives 0x1234, 0x5678, 0x9ABC, 0xDEF0; registers_out[read_addr] matches read_data each time.
- Write-enable gating: we=0, write_addr=1, write_data=0xFFFF, clock several cycles -> reg1 stays 0x5678.
- Out-of-range: we=1, write_addr=4'hA, write_data=0xBEEF -> all four registers unchanged.
- Same-address read/write: read_addr=2, we=1, write_addr=2, write_data=0x0F0F -> before the edge, read_data = 0x9ABC (default) or 0x0F0F (SCALAR_REGS_BYPASS_EN); after the edge it is 0x0F0F in both builds.
- Combinational read: hold clk, switch read_addr 3->0 -> read_data changes 0xDEF0 -> 0x1234 with no clock edge.
